alu_seq: RTL
============

# alu_seq

Parametrised, handshaked, multi-cycle successor to the 16-bit combinational ALU. It accepts one operation at a time over a valid/ready input channel, executes logic/add/sub in one cycle and shifts/multiply iteratively, and returns a registered result with flags over a valid/ready output channel. It sits between the operand/opcode source (register file or testbench driver) and the result consumer.

## Interface
- WIDTH, 16: operand and result width; must be at least 4.
- SHW, $clog2(WIDTH): width of the shift amount taken from b[SHW-1:0].
- clk input 1: clock; all state changes on the rising edge.
- rst input 1: synchronous, active-high reset.
- in_valid input 1: an operation is presented.
- in_ready output 1: the block can accept an operation; high only in IDLE.
- a, b input WIDTH: operands.
- cin input 1: carry/borrow in, used by ADD and SUB.
- opc input 3: opcode, values listed under Operation.
- out_valid output 1: the result and flags are valid.
- out_ready input 1: the consumer takes the result.
- w output WIDTH: result.
- zero, neg, cout, ovf, err output 1 each: flags.

## Operation
- Opcodes:
  - 0 ADD: a+b+cin.
  - 1 SUB: a-b-cin.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: logical shift of a left by b[SHW-1:0].
  - 6 SHR: logical shift of a right by b[SHW-1:0].
  - 7 MUL: low WIDTH bits of unsigned a*b.
- FSM states IDLE, BUSY, DONE; reset state is IDLE.
  - IDLE to DONE: on in_valid for opcodes 0–4, or for a shift with amount 0.
  - IDLE to BUSY: for a shift with amount n>0, or for MUL.
  - BUSY: one shift step per cycle, or one shift-add step per cycle for MUL; go to DONE when the count expires.
  - DONE to IDLE: on out_ready.
- Operands, opcode and cin are captured on acceptance. Input changes after that have no effect.
- Flags are registered together with w:
  - zero: w==0.
  - neg: w[WIDTH-1].
  - cout, ADD: carry out of bit WIDTH-1.
  - cout, SUB: 1 when no borrow occurred.
  - cout, SHL/SHR: the last bit shifted out; 0 when n=0.
  - cout, MUL: 1 if any product bit at or above WIDTH is nonzero.
  - cout, logic ops: 0.
  - ovf: signed overflow for ADD/SUB; 0 for every other opcode.
  - err: set only for opcode 7 when the multiply option is compiled out (see Configuration).
- All arithmetic wraps modulo 2^WIDTH. There is no saturation.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0.
  - w=0.
  - all flags 0.
  - FSM in IDLE; iteration counter 0.
- Acceptance happens on the edge where in_valid and in_ready are both 1 (call it cycle T).
- Latency from acceptance to out_valid:
  - opcodes 0–4: T+1.
  - SHL/SHR: T+1+n.
  - MUL: T+1+WIDTH.
- out_valid and w/flags stay stable until the edge where out_ready=1. out_valid drops at the next cycle.
- in_ready rises in the cycle after out_ready is taken. There is no overlap: throughput is at most one operation every 2 cycles.
- While out_valid=1 and out_ready=0, in_ready=0 and in_valid is ignored. This back-pressure may hold indefinitely.
- Reset asserted in BUSY or DONE aborts the operation and gives the reset values on the next edge. No result is emitted.
- in_valid during BUSY is ignored. The block does not queue operations.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - opcode 7 performs the iterative WIDTH-cycle shift-add multiply.
  - err is held 0.
- ALU_SEQ_MUL_EN undefined:
  - the multiplier datapath and its counter range are removed.
  - opcode 7 completes like a one-cycle op: out_valid at T+1, w=0, zero=1, err=1, other flags 0.

## Structure
- Package alu_seq_pkg holds:
  - typedef enum logic [2:0] for the opcodes (OP_ADD … OP_MUL).
  - the state enum (ST_IDLE, ST_BUSY, ST_DONE).
- Sub-module alu_seq_core: the combinational one-cycle unit (opcodes 0–4 plus flag generation), parametrised by WIDTH.
- The top level holds the FSM, operand registers, iteration counter and the shift/MUL datapath.

## Test plan
- WIDTH=16:
  - ADD a=16'hFFFF, b=16'h0001, cin=0 → w=0, zero=1, cout=1, ovf=0, out_valid at T+1.
  - SUB a=16'h8000, b=16'h0001, cin=0 → w=16'h7FFF, ovf=1, cout=1, neg=0.
  - SHL a=16'h8001, b=4 → w=16'h0010, cout=0, out_valid exactly at T+5; in_ready=0 throughout.
  - MUL a=300, b=300 with ALU_SEQ_MUL_EN → w=16'h5F90, cout=1, out_valid at T+17. Without the macro → w=0, err=1 at T+1.
- Back-pressure: hold out_ready=0 for 10 cycles after an XOR result.
  - w and flags stay stable, in_ready stays 0.
  - A new in_valid in that window is not accepted.
- Assert rst mid-MUL at T+5.
  - The next cycle shows out_valid=0, in_ready=1, w=0.
  - An ADD issued afterwards completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings, flag bundle.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } opc_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic cout;
        logic ovf;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_seq_core.sv
// Single-cycle combinational unit for ADD/SUB/AND/OR/XOR with carry and signed-overflow outputs.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  opc_e             opc_i,
    output logic [WIDTH-1:0] w_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    assign sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    assign dif = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};

    always_comb begin
        w_o    = '0;
        cout_o = 1'b0;
        ovf_o  = 1'b0;
        case (opc_i)
            OP_ADD: begin
                w_o    = sum[WIDTH-1:0];
                cout_o = sum[WIDTH];
                ovf_o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // cout is "no borrow", i.e. the inverted top bit of the wide difference
                w_o    = dif[WIDTH-1:0];
                cout_o = ~dif[WIDTH];
                ovf_o  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  w_o = a_i & b_i;
            OP_OR:   w_o = a_i | b_i;
            OP_XOR:  w_o = a_i ^ b_i;
            default: w_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: one-cycle logic/add/sub, bit-serial shifts and shift-add multiply.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise opcode 7 returns err=1.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       opc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] w,
    output logic             zero,
    output logic             neg,
    output logic             cout,
    output logic             ovf,
    output logic             err
);

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);
`else
    localparam int CNT_W = SHW;
`endif

    state_e             st_q, st_d;
    opc_e               op_q, op_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   w_q, w_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    flags_t             fl_q, fl_d;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_nx;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     psum;
`endif

    logic [WIDTH-1:0]   core_w;
    logic               core_cout, core_ovf;
    logic [SHW-1:0]     amt;
    logic [WIDTH-1:0]   sh_step;
    logic               sh_out;
    logic               last;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a_i    (a),
        .b_i    (b),
        .cin_i  (cin),
        .opc_i  (opc_e'(opc)),
        .w_o    (core_w),
        .cout_o (core_cout),
        .ovf_o  (core_ovf)
    );

    function automatic flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                        input logic o, input logic e);
        flags_t f;
        f.zero = (r == '0);
        f.neg  = r[WIDTH-1];
        f.cout = c;
        f.ovf  = o;
        f.err  = e;
        return f;
    endfunction

    assign amt  = b[SHW-1:0];
    assign last = (cnt_q == CNT_W'(1));

    // One bit per cycle; the bit falling off the end becomes cout on the final step
    always_comb begin
        if (op_q == OP_SHL) begin
            sh_step = {sh_q[WIDTH-2:0], 1'b0};
            sh_out  = sh_q[WIDTH-1];
        end else begin
            sh_step = {1'b0, sh_q[WIDTH-1:1]};
            sh_out  = sh_q[0];
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // prod_q = {partial sum, remaining multiplier bits}; add then shift right once per cycle
    assign psum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_nx = {psum, prod_q[WIDTH-1:1]};
`endif

    always_comb begin
        st_d  = st_q;
        op_d  = op_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        w_d   = w_q;
        fl_d  = fl_q;
`ifdef ALU_SEQ_MUL_EN
        prod_d  = prod_q;
        mcand_d = mcand_q;
`endif
        unique case (st_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = opc_e'(opc);
                    case (opc_e'(opc))
                        OP_SHL, OP_SHR: begin
                            if (amt == '0) begin
                                w_d  = a;
                                fl_d = mk_flags(a, 1'b0, 1'b0, 1'b0);
                                st_d = ST_DONE;
                            end else begin
                                sh_d  = a;
                                cnt_d = CNT_W'(amt);
                                st_d  = ST_BUSY;
                            end
                        end
                        OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                            mcand_d = a;
                            prod_d  = {{WIDTH{1'b0}}, b};
                            cnt_d   = CNT_W'(WIDTH);
                            st_d    = ST_BUSY;
`else
                            w_d  = '0;
                            fl_d = mk_flags('0, 1'b0, 1'b0, 1'b1);
                            st_d = ST_DONE;
`endif
                        end
                        default: begin
                            w_d  = core_w;
                            fl_d = mk_flags(core_w, core_cout, core_ovf, 1'b0);
                            st_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
                if (op_q == OP_MUL) begin
                    prod_d = prod_nx;
                    if (last) begin
                        w_d  = prod_nx[WIDTH-1:0];
                        fl_d = mk_flags(prod_nx[WIDTH-1:0], |prod_nx[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
                        st_d = ST_DONE;
                    end
                end else
`endif
                begin
                    sh_d = sh_step;
                    if (last) begin
                        w_d  = sh_step;
                        fl_d = mk_flags(sh_step, sh_out, 1'b0, 1'b0);
                        st_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            op_q  <= OP_ADD;
            sh_q  <= '0;
            cnt_q <= '0;
            w_q   <= '0;
            fl_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= '0;
            mcand_q <= '0;
`endif
        end else begin
            st_q  <= st_d;
            op_q  <= op_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            w_q   <= w_d;
            fl_q  <= fl_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
`endif
        end
    end

    assign in_ready  = (st_q == ST_IDLE);
    assign out_valid = (st_q == ST_DONE);
    assign w         = w_q;
    assign zero      = fl_q.zero;
    assign neg       = fl_q.neg;
    assign cout      = fl_q.cout;
    assign ovf       = fl_q.ovf;
    assign err       = fl_q.err;

endmodule
